// File: rtl/tone_pkg.sv
// -----------------------------------------------------------------------------
// tone_pkg
// Shared types and constants for the tone sequencer.
//   state_t        : sequencer states (IDLE, LOAD, NOTE, GAP)
//   note_t         : one note table entry {half_period, dur_ms}
//   END_MARKER_DUR : dur_ms value that terminates a melody
// -----------------------------------------------------------------------------
package tone_pkg;

   // Field widths of one table entry. The sequencer's PERIOD_W / DUR_W
   // parameters default to these and must stay equal to them.
   localparam int NOTE_PERIOD_W = 17;
   localparam int NOTE_DUR_W    = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      NOTE = 2'd2,
      GAP  = 2'd3
   } state_t;

   typedef struct packed {
      logic [NOTE_PERIOD_W-1:0] half_period;
      logic [NOTE_DUR_W-1:0]    dur_ms;
   } note_t;

   // An entry with zero duration ends the melody.
   localparam logic [NOTE_DUR_W-1:0] END_MARKER_DUR = '0;

endpackage

// File: rtl/tone_osc.sv
// -----------------------------------------------------------------------------
// tone_osc
// Square-wave oscillator driven by a half-period count in clock cycles.
//   clk, rst_n  : clock, synchronous active-low reset
//   en          : run the oscillator; when low the counter clears and gpio is 0
//   half_period : cycles between gpio toggles; 0 means a rest (gpio held 0)
//   gpio        : square-wave output
// -----------------------------------------------------------------------------
module tone_osc #(
   parameter int PERIOD_W = 17
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [PERIOD_W-1:0] half_period,
   output logic                gpio
);

   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic                gpio_q, gpio_d;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, with blocking
      // assignments, so no path can leave it unassigned and infer a latch.
      cnt_d  = cnt_q;
      gpio_d = gpio_q;
      if (!en || half_period == '0) begin
         cnt_d  = '0;
         gpio_d = 1'b0;
      end else if (cnt_q == half_period - 1'b1) begin
         cnt_d  = '0;
         gpio_d = ~gpio_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // its pre-edge inputs regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         gpio_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         gpio_q <= gpio_d;
      end
   end

   // Gate with en so gpio drops in the very cycle the note ends, even if the
   // flop toggled on that same edge.
   assign gpio = en & gpio_q;

endmodule

// File: rtl/tone_sequencer.sv
// -----------------------------------------------------------------------------
// tone_sequencer
// Plays a melody from a 16-entry note table onto a square-wave GPIO, with a
// fixed silent gap after every note.
//   clk, rst_n        : clock, synchronous active-low reset
//   wr_en/addr/data   : note table write port, data = {half_period, dur_ms}
//   start             : pulse, begin playback at entry 0 (ignored while busy)
//   stop              : pulse, abort playback; wins over start
//   busy              : high from LOAD through GAP
//   done              : one-cycle pulse on normal end of melody
//   note_idx          : index of the entry currently playing
//   gpio              : audio output
// Build option: define TONE_SEQ_LOOP_EN to restart at entry 0 after the end
// of the melody instead of returning to IDLE; only stop ends playback.
// -----------------------------------------------------------------------------
module tone_sequencer
   import tone_pkg::*;
#(
   parameter int TICK_DIV  = 50000,
   parameter int NUM_NOTES = 16,
   parameter int PERIOD_W  = NOTE_PERIOD_W,
   parameter int DUR_W     = NOTE_DUR_W,
   parameter int GAP_MS    = 20
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en,
   input  logic [$clog2(NUM_NOTES)-1:0] wr_addr,
   input  logic [PERIOD_W+DUR_W-1:0]    wr_data,
   input  logic                         start,
   input  logic                         stop,
   output logic                         busy,
   output logic                         done,
   output logic [$clog2(NUM_NOTES)-1:0] note_idx,
   output logic                         gpio
);

   localparam int IDX_W  = $clog2(NUM_NOTES);
   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   note_t             note_tbl_q [NUM_NOTES];
   note_t             rd_entry;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic [DUR_W-1:0]  ms_q, ms_d;
   note_t             note_q, note_d;
   logic              done_q, done_d;
   logic              tick_wrap;
   logic              melody_end;

   // NOTE: the note table has no reset; software loads it before use, and
   // leaving it unreset lets it map onto plain storage.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         note_tbl_q[wr_addr] <= note_t'(wr_data);
      end
   end

   // LOAD captures this into note_q; a same-cycle write to the same entry
   // lands after the edge, so LOAD sees the old contents.
   assign rd_entry  = note_tbl_q[idx_q];
   assign tick_wrap = (tick_q == TICK_W'(TICK_DIV - 1));

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      tick_d     = tick_q;
      ms_d       = ms_q;
      note_d     = note_q;
      done_d     = 1'b0;
      melody_end = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
               idx_d   = '0;
            end
         end
         LOAD: begin
            note_d = rd_entry;
            if (rd_entry.dur_ms == END_MARKER_DUR) begin
               melody_end = 1'b1;
            end else begin
               state_d = NOTE;
            end
         end
         NOTE: begin
            if (tick_wrap) begin
               tick_d = '0;
               if (ms_q == note_q.dur_ms - 1'b1) begin
                  state_d = GAP;
               end else begin
                  ms_d = ms_q + 1'b1;
               end
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         GAP: begin
            if (tick_wrap) begin
               tick_d = '0;
               if (ms_q == DUR_W'(GAP_MS - 1)) begin
                  if (idx_q == IDX_W'(NUM_NOTES - 1)) begin
                     melody_end = 1'b1;
                  end else begin
                     idx_d   = idx_q + 1'b1;
                     state_d = LOAD;
                  end
               end else begin
                  ms_d = ms_q + 1'b1;
               end
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
      endcase

      if (melody_end) begin
         done_d = 1'b1;
         idx_d  = '0;
`ifdef TONE_SEQ_LOOP_EN
         state_d = LOAD;
`else
         state_d = IDLE;
`endif
      end

      // stop overrides everything, including a start in the same cycle.
      if (stop) begin
         state_d = IDLE;
         idx_d   = '0;
         done_d  = 1'b0;
      end

      // Timing always restarts from zero on a state change.
      if (state_d != state_q) begin
         tick_d = '0;
         ms_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         tick_q  <= '0;
         ms_q    <= '0;
         note_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tick_q  <= tick_d;
         ms_q    <= ms_d;
         note_q  <= note_d;
         done_q  <= done_d;
      end
   end

   tone_osc #(
      .PERIOD_W (NOTE_PERIOD_W)
   ) u_osc (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (state_q == NOTE),
      .half_period (note_q.half_period),
      .gpio        (gpio)
   );

   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign note_idx = idx_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tone_sequencer
// Self-checking bench for tone_sequencer with TICK_DIV=10, GAP_MS=2. A
// reference model tracks playback as an offset within the current entry
// (0 = LOAD, 1..dur*TICK_DIV = tone, then the gap) and predicts busy, done,
// note_idx and gpio every cycle. Define TONE_SEQ_LOOP_EN for the looping build.
// -----------------------------------------------------------------------------
module tb_tone_sequencer;

   localparam int TICK_DIV  = 10;
   localparam int GAP_MS    = 2;
   localparam int NUM_NOTES = 16;
   localparam int GAP_CYC   = GAP_MS * TICK_DIV;
`ifdef TONE_SEQ_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [26:0] wr_data = '0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        busy, done, gpio;
   logic [3:0]  note_idx;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   tone_sequencer #(
      .TICK_DIV  (TICK_DIV),
      .NUM_NOTES (NUM_NOTES),
      .PERIOD_W  (17),
      .DUR_W     (10),
      .GAP_MS    (GAP_MS)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .start    (start),
      .stop     (stop),
      .busy     (busy),
      .done     (done),
      .note_idx (note_idx),
      .gpio     (gpio)
   );

   // ---------------- reference model ----------------
   int m_hp  [NUM_NOTES];
   int m_dur [NUM_NOTES];
   bit m_busy, m_done;
   int m_idx, m_t, m_cur_hp, m_cur_dur;

   function automatic void model_end();
      m_done = 1'b1;
      m_idx  = 0;
      m_t    = 0;
      if (!LOOP) m_busy = 1'b0;
   endfunction

   function automatic void model_edge(input bit rst_low, input bit st, input bit sp,
                                      input bit we, input int wa, input int whp,
                                      input int wdur);
      if (rst_low) begin
         m_busy = 1'b0; m_done = 1'b0; m_idx = 0; m_t = 0;
         m_cur_hp = 0; m_cur_dur = 0;
      end else begin
         m_done = 1'b0;
         if (sp) begin
            m_busy = 1'b0; m_idx = 0; m_t = 0;
         end else if (!m_busy) begin
            if (st) begin
               m_busy = 1'b1; m_idx = 0; m_t = 0;
            end
         end else if (m_t == 0) begin
            if (m_dur[m_idx] == 0) begin
               model_end();
            end else begin
               m_cur_hp  = m_hp[m_idx];
               m_cur_dur = m_dur[m_idx];
               m_t       = 1;
            end
         end else if (m_t == m_cur_dur * TICK_DIV + GAP_CYC) begin
            if (m_idx == NUM_NOTES - 1) model_end();
            else begin
               m_idx = m_idx + 1;
               m_t   = 0;
            end
         end else begin
            m_t = m_t + 1;
         end
      end
      // The write lands after any read made on this edge.
      if (we) begin
         m_hp[wa]  = whp;
         m_dur[wa] = wdur;
      end
   endfunction

   function automatic int exp_gpio();
      int k;
      if (m_busy && m_t >= 1 && m_t <= m_cur_dur * TICK_DIV) begin
         k = m_t - 1;
         if (m_cur_hp == 0) return 0;
         return (k / m_cur_hp) % 2;
      end
      return 0;
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   // Drive one cycle of inputs (from a negedge), advance the model at the
   // posedge, and compare all outputs at the following negedge.
   task automatic cycle(input bit rst_low, input bit st, input bit sp, input bit we,
                        input int wa, input int whp, input int wdur);
      logic [31:0] hp_v, dur_v;
      hp_v    = whp;
      dur_v   = wdur;
      rst_n   = ~rst_low;
      start   = st;
      stop    = sp;
      wr_en   = we;
      wr_addr = 4'(wa);
      wr_data = {hp_v[16:0], dur_v[9:0]};
      @(posedge clk);
      model_edge(rst_low, st, sp, we, wa, whp, wdur);
      @(negedge clk);
      rst_n = 1'b1; start = 1'b0; stop = 1'b0; wr_en = 1'b0;
      check("busy",     32'(busy),     32'(m_busy));
      check("done",     32'(done),     32'(m_done));
      check("note_idx", 32'(note_idx), 32'(m_idx));
      check("gpio",     32'(gpio),     32'(exp_gpio()));
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
   endtask

   task automatic write_note(input int a, input int hp, input int dur);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, a, hp, dur);
   endtask

   task automatic do_start();
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
   endtask

   task automatic do_stop();
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
   endtask

   // Run until the model says playback ended, bounded by max cycles. The
   // looping build never ends by itself, so it is stopped after the budget.
   task automatic run_out(input int max);
      int n;
      n = 0;
      while (m_busy && n < max) begin
         idle(1);
         n++;
      end
`ifdef TONE_SEQ_LOOP_EN
      do_stop();
`else
      if (n >= max) check("play_timeout", 32'(busy), 32'd0);
`endif
      idle(2);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // Reset and reset-state checks.
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_gpio", 32'(gpio), 32'd0);
      idle(3);

      // Single tone then end marker.
      write_note(0, 5, 3);
      write_note(1, 0, 0);
      do_start();
      check("start_busy", 32'(busy), 32'd1);
      run_out(1500);

      // Rest, short tone, end marker.
      write_note(0, 0, 2);
      write_note(1, 3, 1);
      write_note(2, 0, 0);
      do_start();
      run_out(1500);

      // Stop mid-note, then replay from entry 0.
      write_note(0, 5, 3);
      write_note(1, 0, 0);
      do_start();
      idle(12);
      do_stop();
      check("stop_busy", 32'(busy), 32'd0);
      check("stop_done", 32'(done), 32'd0);
      do_start();
      run_out(1500);

      // All 16 entries with non-zero durations.
      for (int i = 0; i < NUM_NOTES; i++)
         write_note(i, $urandom_range(0, 6), $urandom_range(1, 2));
      do_start();
      run_out(1500);

      // Rewrite entry 1 while entry 0 plays: new value heard.
      write_note(0, 4, 2);
      write_note(1, 7, 1);
      write_note(2, 0, 0);
      do_start();
      idle(5);
      write_note(1, 2, 1);
      run_out(1500);

      // Write during the LOAD of the same entry: old value heard.
      write_note(0, 3, 1);
      write_note(1, 5, 1);
      write_note(2, 0, 0);
      do_start();
      n = 0;
      while (!(m_busy && m_t == 0 && m_idx == 1) && n < 200) begin
         idle(1);
         n++;
      end
      write_note(1, 2, 2);
      run_out(1500);

      // start and stop together: stays idle.
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0);
      check("start_stop_busy", 32'(busy), 32'd0);
      idle(3);

      // start while busy is ignored; reset mid-note clears outputs.
      write_note(0, 2, 2);
      write_note(1, 0, 0);
      do_start();
      idle(4);
      do_start();
      idle(3);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_gpio", 32'(gpio), 32'd0);
      idle(3);

      // Randomized tables and control traffic.
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < NUM_NOTES; i++)
            write_note(i, $urandom_range(0, 6),
                       ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 2));
         do_start();
         for (int c = 0; c < 300; c++) begin
            bit st, sp, we;
            st = ($urandom_range(0, 19) == 0);
            sp = ($urandom_range(0, 149) == 0);
            we = ($urandom_range(0, 14) == 0);
            cycle(1'b0, st, sp, we, $urandom_range(0, NUM_NOTES - 1),
                  $urandom_range(0, 6), $urandom_range(0, 2));
         end
         do_stop();
         idle(2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
